stopwatch_lap_ctrl: RTL and testbench
=====================================

// Module: stopwatch_lap_ctrl
// PURPOSE
//  Parametrised stopwatch controller: run/pause/clear FSM, NUM_LAPS-deep lap capture memory and lap review.
//  Sits between the debounced button inputs and the time counter / display mux.
//  Outputs run-enable and clear to the counter, and selects live time or a stored lap for the display.
// PARAMETERS
//  TIME_W    24  width of time value from counter (time_in) and of stored laps
//  NUM_LAPS  4   lap memory depth (>=1)
//  IDX_W     2   lap index width; 2**IDX_W >= NUM_LAPS
// PORTS
//  clk            in   1        system clock; all logic on rising edge
//  rst            in   1        synchronous, active-high reset
//  start_stop     in   1        debounced level button; rising edge = start/stop event
//  lap            in   1        debounced level button; rising edge = lap/next event
//  clear          in   1        debounced level button; rising edge = clear event
//  time_in        in   TIME_W   live elapsed time from counter
//  running        out  1        counter enable
//  counter_clear  out  1        one-cycle pulse: zero the counter
//  disp_time      out  TIME_W   value to display (live or stored lap)
//  disp_is_lap    out  1        1 = disp_time is a stored lap
//  disp_idx       out  IDX_W    lap index shown (valid when disp_is_lap)
//  lap_count      out  IDX_W+1  number of laps stored, 0..NUM_LAPS
//  lap_full       out  1        lap_count == NUM_LAPS
//  lap_overflow   out  1        one-cycle pulse: lap event while full, lap dropped
// BEHAVIOUR
//  Edge detect: one prev-register per button; event = in & ~prev, judged in the cycle it is sampled.
//  Register stages: a level held high gives exactly one event; prev registers reset to 0,
//  so a button held high through reset fires one event in the first cycle after reset.
//  All outputs registered: effect of an event is visible after the next clk edge (1-cycle latency).
//  Event priority in the same cycle: clear > start_stop > lap; lower-priority events that cycle are dropped.
//  Reset (any state, any cycle): state=IDLE, running=0, counter_clear=0, disp_time=0,
//   disp_is_lap=0, disp_idx=0, lap_count=0, lap_overflow=0, prev regs=0. Lap memory contents don't-care.
//  States:
//   IDLE   running=0. start_stop -> RUN. clear -> counter_clear pulse, stay. lap ignored.
//   RUN    running=1. start_stop -> PAUSE. clear ignored.
//          lap: if !lap_full, mem[lap_count] <= time_in of the event cycle, lap_count+1.
//          lap while lap_full: no write, lap_overflow pulse.
//   PAUSE  running=0. start_stop -> RUN. clear -> IDLE, counter_clear pulse, lap_count <= 0.
//          lap: if lap_count>0 -> REVIEW, disp_idx <= 0; if lap_count==0 ignored.
//   REVIEW running=0. lap: disp_idx+1; if disp_idx == lap_count-1 -> PAUSE, disp_idx <= 0 (wrap to live).
//          start_stop -> RUN (live display). clear -> as in PAUSE.
//  Display: in REVIEW, disp_time <= mem[disp_idx] and disp_is_lap=1; all other states,
//   disp_time <= time_in and disp_is_lap=0.
//  Illegal state encoding -> IDLE next cycle with reset output values.
//  counter_clear and lap_overflow are never high for two consecutive cycles.
// TESTING
//  1 rst, start_stop edge, 10 cycles, start_stop edge -> running=1 the cycle after the first event
//    and 0 the cycle after the second; state PAUSE.
//  2 RUN, lap edges when time_in=100 and 250 -> lap_count=2. Pause, lap -> disp_time=100, disp_is_lap=1.
//    lap -> 250. lap -> live time_in, disp_is_lap=0.
//  3 NUM_LAPS=4: 5 lap events in RUN -> lap_count=4, lap_full=1, one lap_overflow pulse on the 5th.
//    mem holds the first 4 times.
//  4 start_stop and clear rising together in PAUSE with laps stored -> IDLE, counter_clear pulse,
//    lap_count=0, running stays 0.
//  5 start_stop held high 20 cycles -> exactly one transition; clear in RUN -> no pulse, still RUN.
//  6 rst asserted mid-REVIEW -> all outputs at reset values next cycle; lap edge in IDLE -> no change.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: run/pause/clear FSM, lap capture memory and lap review display select.
// Latency: every output is registered, so a button event shows its effect one clk after it is sampled.
// Backpressure: none; each button rising edge is acted on or dropped in the cycle it is sampled.
module stopwatch_lap_ctrl #(
    parameter int TIME_W   = 24,
    parameter int NUM_LAPS = 4,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    input  logic [TIME_W-1:0] time_in,
    output logic              running,
    output logic              counter_clear,
    output logic [TIME_W-1:0] disp_time,
    output logic              disp_is_lap,
    output logic [IDX_W-1:0]  disp_idx,
    output logic [IDX_W:0]    lap_count,
    output logic              lap_full,
    output logic              lap_overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSE  = 2'd2,
        S_REVIEW = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ss_prev_q, lap_prev_q, clr_prev_q;
    logic               running_q, running_d;
    logic               counter_clear_q, counter_clear_d;
    logic [TIME_W-1:0]  disp_time_q, disp_time_d;
    logic               disp_is_lap_q, disp_is_lap_d;
    logic [IDX_W-1:0]   disp_idx_q, disp_idx_d;
    logic [IDX_W:0]     lap_count_q, lap_count_d;
    logic               lap_overflow_q, lap_overflow_d;
    logic [TIME_W-1:0]  mem_q [NUM_LAPS];
    logic               mem_we;
    logic               illegal;

    // Raw rising edges, then priority: clear beats start_stop beats lap.
    logic raw_ss, raw_lap, raw_clr;
    logic ev_ss, ev_lap, ev_clr;
    assign raw_ss  = start_stop & ~ss_prev_q;
    assign raw_lap = lap & ~lap_prev_q;
    assign raw_clr = clear & ~clr_prev_q;
    assign ev_clr  = raw_clr;
    assign ev_ss   = raw_ss & ~raw_clr;
    assign ev_lap  = raw_lap & ~raw_ss & ~raw_clr;

    assign lap_full = (lap_count_q == (IDX_W+1)'(NUM_LAPS));

    // Next-state, lap bookkeeping and registered output values.
    always_comb begin
        state_d         = state_q;
        counter_clear_d = 1'b0;
        lap_overflow_d  = 1'b0;
        lap_count_d     = lap_count_q;
        disp_idx_d      = disp_idx_q;
        mem_we          = 1'b0;
        illegal         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev_clr) begin
                    counter_clear_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_ss) begin
                    state_d = S_PAUSE;
                end else if (ev_lap) begin
                    if (!lap_full) begin
                        mem_we      = 1'b1;
                        lap_count_d = lap_count_q + (IDX_W+1)'(1);
                    end else begin
                        lap_overflow_d = 1'b1;
                    end
                end
            end
            S_PAUSE, S_REVIEW: begin
                if (ev_clr) begin
                    state_d         = S_IDLE;
                    counter_clear_d = 1'b1;
                    lap_count_d     = '0;
                end else if (ev_ss) begin
                    state_d = S_RUN;
                end else if (ev_lap) begin
                    if (state_q == S_PAUSE) begin
                        if (lap_count_q != '0) begin
                            state_d    = S_REVIEW;
                            disp_idx_d = '0;
                        end
                    end else if ({1'b0, disp_idx_q} == lap_count_q - (IDX_W+1)'(1)) begin
                        // Last stored lap shown: fall back to the live display.
                        state_d    = S_PAUSE;
                        disp_idx_d = '0;
                    end else begin
                        disp_idx_d = disp_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                lap_count_d = '0;
                illegal     = 1'b1;
            end
        endcase
        running_d     = (state_d == S_RUN);
        disp_is_lap_d = (state_d == S_REVIEW);
        if (!disp_is_lap_d) begin
            disp_idx_d = '0;
        end
        if (illegal) begin
            disp_time_d = '0;
        end else if (disp_is_lap_d) begin
            disp_time_d = mem_q[disp_idx_d];
        end else begin
            disp_time_d = time_in;
        end
    end

    // State, edge-detect and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ss_prev_q       <= 1'b0;
            lap_prev_q      <= 1'b0;
            clr_prev_q      <= 1'b0;
            running_q       <= 1'b0;
            counter_clear_q <= 1'b0;
            disp_time_q     <= '0;
            disp_is_lap_q   <= 1'b0;
            disp_idx_q      <= '0;
            lap_count_q     <= '0;
            lap_overflow_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            ss_prev_q       <= start_stop;
            lap_prev_q      <= lap;
            clr_prev_q      <= clear;
            running_q       <= running_d;
            counter_clear_q <= counter_clear_d;
            disp_time_q     <= disp_time_d;
            disp_is_lap_q   <= disp_is_lap_d;
            disp_idx_q      <= disp_idx_d;
            lap_count_q     <= lap_count_d;
            lap_overflow_q  <= lap_overflow_d;
        end
    end

    // Lap memory: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[lap_count_q[IDX_W-1:0]] <= time_in;
        end
    end

    assign running       = running_q;
    assign counter_clear = counter_clear_q;
    assign disp_time     = disp_time_q;
    assign disp_is_lap   = disp_is_lap_q;
    assign disp_idx      = disp_idx_q;
    assign lap_count     = lap_count_q;
    assign lap_overflow  = lap_overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: directed scenarios then random button traffic.
// Latency: outputs compared one clk after the inputs that cause them.
// Backpressure: not applicable.
module tb_stopwatch_lap_ctrl;

    localparam int TIME_W   = 24;
    localparam int NUM_LAPS = 4;
    localparam int IDX_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_stop, lap, clear;
    logic [TIME_W-1:0] time_in;
    logic              running, counter_clear, disp_is_lap, lap_full, lap_overflow;
    logic [TIME_W-1:0] disp_time;
    logic [IDX_W-1:0]  disp_idx;
    logic [IDX_W:0]    lap_count;

    int total = 0;
    int bad   = 0;

    stopwatch_lap_ctrl #(.TIME_W(TIME_W), .NUM_LAPS(NUM_LAPS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
        .time_in(time_in), .running(running), .counter_clear(counter_clear),
        .disp_time(disp_time), .disp_is_lap(disp_is_lap), .disp_idx(disp_idx),
        .lap_count(lap_count), .lap_full(lap_full), .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode by name, stored laps as a queue.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_REVIEW = 3;
    int          m_mode = M_IDLE;
    int unsigned m_laps[$];
    int          m_ridx = 0;
    logic        m_pss = 0, m_plp = 0, m_pcl = 0;
    logic [31:0] e_disp = 0;
    logic        e_cc = 0, e_ovf = 0;

    task automatic model_step(input logic ss_i, lp_i, cl_i, rs_i, input logic [TIME_W-1:0] tin_i);
        bit do_clr, do_ss, do_lap;
        if (rs_i) begin
            m_mode = M_IDLE; m_laps.delete(); m_ridx = 0;
            m_pss = 0; m_plp = 0; m_pcl = 0;
            e_cc = 0; e_ovf = 0; e_disp = 0;
            return;
        end
        do_clr = cl_i && !m_pcl;
        do_ss  = ss_i && !m_pss && !do_clr;
        do_lap = lp_i && !m_plp && !do_clr && !(ss_i && !m_pss);
        m_pss = ss_i; m_plp = lp_i; m_pcl = cl_i;
        e_cc = 0; e_ovf = 0;
        if (m_mode == M_IDLE) begin
            if (do_clr) e_cc = 1;
            else if (do_ss) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (do_ss) m_mode = M_PAUSE;
            else if (do_lap) begin
                if (m_laps.size() < NUM_LAPS) m_laps.push_back(int'(tin_i));
                else e_ovf = 1;
            end
        end else begin
            if (do_clr) begin
                m_mode = M_IDLE; e_cc = 1; m_laps.delete();
            end else if (do_ss) begin
                m_mode = M_RUN;
            end else if (do_lap) begin
                if (m_mode == M_PAUSE) begin
                    if (m_laps.size() > 0) begin m_mode = M_REVIEW; m_ridx = 0; end
                end else if (m_ridx == m_laps.size() - 1) begin
                    m_mode = M_PAUSE; m_ridx = 0;
                end else begin
                    m_ridx++;
                end
            end
        end
        e_disp = (m_mode == M_REVIEW) ? 32'(m_laps[m_ridx]) : 32'(tin_i);
    endtask

    // One cycle: drive at negedge, step the model, compare after the next negedge.
    task automatic tick(input logic ss_i, lp_i, cl_i, rs_i, input logic [TIME_W-1:0] tin_i);
        start_stop = ss_i; lap = lp_i; clear = cl_i; rst = rs_i; time_in = tin_i;
        model_step(ss_i, lp_i, cl_i, rs_i, tin_i);
        @(negedge clk);
        check_val("running",       32'(running),       32'(m_mode == M_RUN));
        check_val("counter_clear", 32'(counter_clear), 32'(e_cc));
        check_val("lap_overflow",  32'(lap_overflow),  32'(e_ovf));
        check_val("disp_is_lap",   32'(disp_is_lap),   32'(m_mode == M_REVIEW));
        check_val("disp_time",     32'(disp_time),     e_disp);
        check_val("lap_count",     32'(lap_count),     32'(m_laps.size()));
        check_val("lap_full",      32'(lap_full),      32'(m_laps.size() == NUM_LAPS));
        if (m_mode == M_REVIEW) check_val("disp_idx", 32'(disp_idx), 32'(m_ridx));
    endtask

    // Button press: one cycle high, one cycle low.
    task automatic press(input logic ss_i, lp_i, cl_i, input logic [TIME_W-1:0] tin_i);
        tick(ss_i, lp_i, cl_i, 1'b0, tin_i);
        tick(1'b0, 1'b0, 1'b0, 1'b0, tin_i + 1);
    endtask

    initial begin
        logic ss_l, lp_l, cl_l;
        // Reset
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        check_val("rst_running", 32'(running), 0);
        check_val("rst_count", 32'(lap_count), 0);

        // 1: start, run 10 cycles, stop
        tick(1, 0, 0, 0, 1);
        check_val("t1_run", 32'(running), 1);
        tick(0, 0, 0, 0, 2);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 24'(3 + i));
        tick(1, 0, 0, 0, 13);
        check_val("t1_stop", 32'(running), 0);
        tick(0, 0, 0, 0, 14);

        // 2: laps at 100 and 250, then review
        press(1, 0, 0, 20);
        press(0, 1, 0, 100);
        press(0, 1, 0, 250);
        press(1, 0, 0, 300);
        tick(0, 1, 0, 0, 301);
        check_val("t2_lap0", 32'(disp_time), 100);
        check_val("t2_islap", 32'(disp_is_lap), 1);
        tick(0, 0, 0, 0, 302);
        tick(0, 1, 0, 0, 303);
        check_val("t2_lap1", 32'(disp_time), 250);
        tick(0, 0, 0, 0, 304);
        tick(0, 1, 0, 0, 305);
        check_val("t2_live", 32'(disp_time), 305);
        check_val("t2_live_flag", 32'(disp_is_lap), 0);
        tick(0, 0, 0, 0, 306);

        // 4: start_stop and clear together in PAUSE with laps stored
        tick(1, 0, 1, 0, 307);
        check_val("t4_cc", 32'(counter_clear), 1);
        check_val("t4_count", 32'(lap_count), 0);
        check_val("t4_run", 32'(running), 0);
        tick(0, 0, 0, 0, 308);
        check_val("t4_cc_pulse", 32'(counter_clear), 0);

        // 3: five laps with NUM_LAPS=4, then review the four kept
        press(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, 0, 24'(11 + i));
            if (i == 4) check_val("t3_ovf", 32'(lap_overflow), 1);
            tick(0, 0, 0, 0, 24'(40 + i));
        end
        check_val("t3_full", 32'(lap_full), 1);
        press(1, 0, 0, 50);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 60);
            check_val("t3_mem", 32'(disp_time), 32'(11 + i));
            tick(0, 0, 0, 0, 61);
        end
        press(0, 1, 0, 62);

        // 5: start_stop held 20 cycles, then clear in RUN
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 24'(70 + i));
        check_val("t5_held", 32'(running), 1);
        tick(0, 0, 0, 0, 90);
        tick(0, 0, 1, 0, 91);
        check_val("t5_clr_ignored", 32'(counter_clear), 0);
        check_val("t5_still_run", 32'(running), 1);
        tick(0, 0, 0, 0, 92);

        // 6: reset mid-review, then lap in IDLE
        press(1, 0, 0, 93);
        press(0, 1, 0, 94);
        check_val("t6_review", 32'(m_mode), M_REVIEW);
        tick(0, 0, 0, 1, 95);
        check_val("t6_rst_islap", 32'(disp_is_lap), 0);
        check_val("t6_rst_disp", 32'(disp_time), 0);
        check_val("t6_rst_count", 32'(lap_count), 0);
        press(0, 1, 0, 96);
        check_val("t6_idle_lap", 32'(lap_count), 0);

        // Random traffic
        ss_l = 0; lp_l = 0; cl_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) ss_l = ~ss_l & ($urandom_range(2) == 0);
            if ($urandom_range(2) == 0) lp_l = ~lp_l;
            if ($urandom_range(9) == 0) cl_l = ~cl_l;
            tick(ss_l, lp_l, cl_l, ($urandom_range(299) == 0), 24'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
